agusec_range_pipe: RTL

AGUSEC_RANGE_PIPE -- requirements
Module: agusec_range_pipe

---
 rtl/agusec_range_pipe_pkg.sv | 18 +
 rtl/agusec_range_pipe_if.sv | 32 +++
 rtl/agusec_range_lane.sv | 85 ++++++++
 rtl/agusec_range_pipe.sv | 98 +++++++++
 4 files changed

// File: rtl/agusec_range_pipe_pkg.sv
// Shared definitions for the AGU security range pipe: tagged-pointer field
// layout and default field widths.
package agusec_range_pipe_pkg;

    localparam int PTR_W       = 64;
    localparam int BOUND_W_DEF = 7;
    localparam int EXP_W_DEF   = 5;

    // Tagged pointer layout, MSB first: exp[63:59] low[58:52] high[51:45] on_low[44] addr[43:0]
    localparam int EXP_LSB    = 59;
    localparam int LOW_LSB    = 52;
    localparam int HIGH_LSB   = 45;
    localparam int ON_LOW_BIT = 44;
    localparam int ADDR_MSB   = 43;

    typedef logic [PTR_W-1:0] ptr_t;

endpackage

// File: rtl/agusec_range_pipe_if.sv
// Per-port request/result bundle between an AGU and the range checker.
interface agusec_range_pipe_if #(
    parameter int NPORT = 2
);
    import agusec_range_pipe_pkg::*;

    // Valid-only flow: a port's request is taken on any clock edge where its
    // in_vld is high and the checker's stall is low; there is no ready, and
    // out_vld pulses for one unstalled cycle per accepted request.
    logic [NPORT-1:0]            in_vld;
    logic [NPORT-1:0][PTR_W-1:0] in_ptr;
    logic [NPORT-1:0]            in_cin;
    logic [NPORT-1:0]            out_vld;
    logic [NPORT-1:0]            out_secq;

    modport master (
        output in_vld,
        output in_ptr,
        output in_cin,
        input  out_vld,
        input  out_secq
    );

    modport slave (
        input  in_vld,
        input  in_ptr,
        input  in_cin,
        output out_vld,
        output out_secq
    );

endinterface

// File: rtl/agusec_range_lane.sv
// One port of the range checker: stage 1 extracts the window bits and wrap
// flag, stage 2 performs the bounds compare and registers the result.
module agusec_range_lane
    import agusec_range_pipe_pkg::*;
#(
    parameter int BOUND_W = BOUND_W_DEF,
    parameter int EXP_W   = EXP_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    input  logic chk_en,
    input  logic in_vld,
    input  ptr_t in_ptr,
    input  logic in_cin,
    output logic out_vld,
    output logic out_secq,
    output logic viol,
    output ptr_t s1_ptr
);

    localparam int WIN_W = BOUND_W + 1;

    logic               s1_vld;
    logic               s1_cin;
    logic               s1_diff;
    logic [WIN_W-1:0]   s1_bits;
    logic [WIN_W-1:0]   bits_d;
    logic               diff_d;
    logic [BOUND_W-1:0] low;
    logic [BOUND_W-1:0] high;
    logic               on_low;
    logic               unbounded;
    logic [WIN_W-1:0]   low_w;
    logic [WIN_W-1:0]   high_w;
    logic               ge;
    logic               le;
    logic               chk_pass;
    logic               pass;

    assign bits_d = WIN_W'(in_ptr[ADDR_MSB:0] >> in_ptr[EXP_LSB +: EXP_W]);
    assign diff_d = in_ptr[HIGH_LSB +: BOUND_W] < in_ptr[LOW_LSB +: BOUND_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld  <= 1'b0;
            s1_cin  <= 1'b0;
            s1_diff <= 1'b0;
            s1_bits <= '0;
            s1_ptr  <= '0;
        end else if (!stall) begin
            s1_vld  <= in_vld;
            s1_cin  <= in_cin;
            s1_diff <= diff_d;
            s1_bits <= bits_d;
            s1_ptr  <= in_ptr;
        end
    end

    // Bounds are widened by one bit so high covers its whole granule.
    assign low       = s1_ptr[LOW_LSB +: BOUND_W];
    assign high      = s1_ptr[HIGH_LSB +: BOUND_W];
    assign on_low    = s1_ptr[ON_LOW_BIT];
    assign unbounded = &s1_ptr[EXP_LSB +: EXP_W];
    assign low_w     = {low, 1'b0};
    assign high_w    = {high, 1'b1};
    assign ge        = unbounded | (s1_bits >= low_w);
    assign le        = unbounded | (high_w >= s1_bits);

    // A wrapped window only needs the bound on the side the pointer sits on.
    assign chk_pass  = s1_cin & (ge | (s1_diff & ~on_low)) & (le | (s1_diff & on_low));
    assign pass      = chk_en ? chk_pass : s1_cin;
    assign viol      = ~stall & s1_vld & s1_cin & chk_en & ~pass;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_vld  <= 1'b0;
            out_secq <= 1'b0;
        end else if (!stall) begin
            out_vld  <= s1_vld;
            out_secq <= s1_vld & pass;
        end
    end

endmodule

// File: rtl/agusec_range_pipe.sv
// Multi-port AGU pointer range checker with sticky first-fault capture and
// saturating per-port violation counters.
module agusec_range_pipe
    import agusec_range_pipe_pkg::*;
#(
    parameter int NPORT   = 2,
    parameter int BOUND_W = BOUND_W_DEF,
    parameter int EXP_W   = EXP_W_DEF,
    parameter int CNT_W   = 16,
    localparam int PW     = (NPORT > 1) ? $clog2(NPORT) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        chk_en,
    input  logic                        stall,
    input  logic                        flt_clr,
    agusec_range_pipe_if.slave          bus,
    output logic                        flt_vld,
    output logic [PW-1:0]               flt_port,
    output ptr_t                        flt_ptr,
    output logic [NPORT-1:0][CNT_W-1:0] vio_cnt
);

    logic [NPORT-1:0] lane_vld;
    logic [NPORT-1:0] lane_secq;
    logic [NPORT-1:0] viol;
    ptr_t             lane_ptr [NPORT];
    logic             any_viol;
    logic [PW-1:0]    first_port;
    ptr_t             first_ptr;

    for (genvar p = 0; p < NPORT; p++) begin : g_lane
        agusec_range_lane #(
            .BOUND_W (BOUND_W),
            .EXP_W   (EXP_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .stall    (stall),
            .chk_en   (chk_en),
            .in_vld   (bus.in_vld[p]),
            .in_ptr   (bus.in_ptr[p]),
            .in_cin   (bus.in_cin[p]),
            .out_vld  (lane_vld[p]),
            .out_secq (lane_secq[p]),
            .viol     (viol[p]),
            .s1_ptr   (lane_ptr[p])
        );
    end

    assign bus.out_vld  = lane_vld;
    assign bus.out_secq = lane_secq;

    // Descending scan so the lowest violating port wins.
    always_comb begin
        any_viol   = 1'b0;
        first_port = '0;
        first_ptr  = '0;
        for (int p = NPORT - 1; p >= 0; p--) begin
            if (viol[p]) begin
                any_viol   = 1'b1;
                first_port = PW'(p);
                first_ptr  = lane_ptr[p];
            end
        end
    end

    // A clear re-arms capture in the same cycle, so a coincident violation is kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flt_vld  <= 1'b0;
            flt_port <= '0;
            flt_ptr  <= '0;
        end else if (flt_clr || !flt_vld) begin
            flt_vld <= any_viol;
            if (any_viol) begin
                flt_port <= first_port;
                flt_ptr  <= first_ptr;
            end else if (flt_clr) begin
                flt_port <= '0;
                flt_ptr  <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vio_cnt <= '0;
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                if (viol[p] && (vio_cnt[p] != {CNT_W{1'b1}})) begin
                    vio_cnt[p] <= vio_cnt[p] + CNT_W'(1);
                end
            end
        end
    end

endmodule
